// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic.
//   REG_W      : register index width
//   ZERO_REG   : index of $0, which never takes part in a dependency
//   hz_state_t : hazard controller state encoding
//   fwd_sel_t  : EX operand source select encoding
package pipeline_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'b00,
    HZ_STALL = 2'b01,
    HZ_FLUSH = 2'b10
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational forwarding comparators.
//   ex_rs/ex_rt           : EX-stage source registers
//   id_rs/id_rt           : ID-stage source registers
//   mem_dst/mem_reg_write : EX/MEM writer
//   wb_dst/wb_reg_write   : MEM/WB writer
//   fwd_a/fwd_b           : EX operand select (FWD_RF / FWD_MEM / FWD_WB)
//   fwd_id_a/fwd_id_b     : ID read port takes WB WriteData
module hazard_fwd_unit
  import pipeline_pkg::*;
#(
  parameter int REG_W = pipeline_pkg::REG_W
) (
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_dst,
  input  logic             wb_reg_write,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_id_a,
  output logic             fwd_id_b
);

  // A writer to $0 never produces a value worth forwarding.
  function automatic logic hit(input logic wr, input logic [REG_W-1:0] dst,
                               input logic [REG_W-1:0] src);
    return wr && (dst != '0) && (dst == src);
  endfunction

  logic mem_a, mem_b, wb_a, wb_b;

  always_comb begin
    mem_a = hit(mem_reg_write, mem_dst, ex_rs);
    mem_b = hit(mem_reg_write, mem_dst, ex_rt);
    wb_a  = hit(wb_reg_write, wb_dst, ex_rs);
    wb_b  = hit(wb_reg_write, wb_dst, ex_rt);

    // MEM holds the younger result, so it wins over WB.
    fwd_a = FWD_RF;
    if (mem_a)     fwd_a = FWD_MEM;
    else if (wb_a) fwd_a = FWD_WB;

    fwd_b = FWD_RF;
    if (mem_b)     fwd_b = FWD_MEM;
    else if (wb_b) fwd_b = FWD_WB;

    fwd_id_a = hit(wb_reg_write, wb_dst, id_rs);
    fwd_id_b = hit(wb_reg_write, wb_dst, id_rt);
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage MIPS pipeline.
//   Clk, Reset (async, active low)
//   ID/EX/MEM/WB register indices and control bits in
//   pc_write, ifid_write                    : PC and IF/ID load enables
//   ifid_flush, idex_flush, exmem_flush     : bubble / flush controls
//   fwd_a, fwd_b, fwd_id_a, fwd_id_b        : forwarding selects
//   hz_state                                : current controller state
//   stall_cnt, flush_cnt                    : saturating event counters
//
// state | meaning
// RUN   | last cycle issued neither stall nor flush
// STALL | last cycle issued a load-use stall
// FLUSH | last cycle had a flush cause (branch, jr or jump)
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = pipeline_pkg::REG_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_jr,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             mem_reg_write,
  input  logic             mem_pc_src,
  input  logic [REG_W-1:0] wb_dst,
  input  logic             wb_reg_write,
  input  logic             id_jump,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_id_a,
  output logic             fwd_id_b,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  hz_state_t  state_q, state_d;
  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       fwd_id_a_raw, fwd_id_b_raw;
  logic       load_use, any_flush, stall_issue;

  hazard_fwd_unit #(.REG_W(REG_W)) u_fwd (
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .mem_dst       (mem_dst),
    .mem_reg_write (mem_reg_write),
    .wb_dst        (wb_dst),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a_raw),
    .fwd_b         (fwd_b_raw),
    .fwd_id_a      (fwd_id_a_raw),
    .fwd_id_b      (fwd_id_b_raw)
  );

  always_comb begin
    load_use = ex_mem_read && (ex_dst != '0) &&
               ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
    any_flush   = mem_pc_src || ex_jr || id_jump;
    // Any redirect discards the stalled instruction anyway.
    stall_issue = load_use && !any_flush;
  end

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= HZ_RUN;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = HZ_RUN;
    if (any_flush)        state_d = HZ_FLUSH;
    else if (stall_issue) state_d = HZ_STALL;
  end

  // Output logic; while Reset is low the pipeline is held and flushed.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    fwd_a       = fwd_a_raw;
    fwd_b       = fwd_b_raw;
    fwd_id_a    = fwd_id_a_raw;
    fwd_id_b    = fwd_id_b_raw;
    if (!Reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      fwd_a       = FWD_RF;
      fwd_b       = FWD_RF;
      fwd_id_a    = 1'b0;
      fwd_id_b    = 1'b0;
    end else if (mem_pc_src) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (ex_jr) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (id_jump) begin
      ifid_flush  = 1'b1;
    end else if (stall_issue) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
    end
  end

  assign hz_state = state_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_issue && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (any_flush && (flush_cnt != '1))   flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  // The bubble inserted by a stall clears ex_mem_read, so a second
  // consecutive stall means the upstream pipeline is broken.
  a_no_double_stall : assert property (@(posedge Clk) disable iff (!Reset)
    !((state_q == HZ_STALL) && stall_issue));

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rs = '0, ex_rt = '0;
  logic [4:0] ex_dst = '0, mem_dst = '0, wb_dst = '0;
  logic       id_uses_rt = 0, ex_mem_read = 0, ex_jr = 0, mem_reg_write = 0;
  logic       mem_pc_src = 0, wb_reg_write = 0, id_jump = 0;

  logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  fwd_a, fwd_b, hz_state;
  logic        fwd_id_a, fwd_id_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_exmem_flush;
  logic [1:0]  s_fwd_a, s_fwd_b, s_hz_state;
  logic        s_fwd_id_a, s_fwd_id_b;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  hazard_control_unit #(.CNT_W(16)) u_dut (
    .Clk(Clk), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .ex_jr(ex_jr), .mem_dst(mem_dst), .mem_reg_write(mem_reg_write),
    .mem_pc_src(mem_pc_src), .wb_dst(wb_dst), .wb_reg_write(wb_reg_write),
    .id_jump(id_jump), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b),
    .hz_state(hz_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  hazard_control_unit #(.CNT_W(3)) u_sat (
    .Clk(Clk), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .ex_jr(ex_jr), .mem_dst(mem_dst), .mem_reg_write(mem_reg_write),
    .mem_pc_src(mem_pc_src), .wb_dst(wb_dst), .wb_reg_write(wb_reg_write),
    .id_jump(id_jump), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .fwd_id_a(s_fwd_id_a), .fwd_id_b(s_fwd_id_b),
    .hz_state(s_hz_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int m_state = 0, m_stall = 0, m_flush = 0, m_stall3 = 0, m_flush3 = 0;
  int p_state = 0, p_stall = 0, p_flush = 0, p_stall3 = 0, p_flush3 = 0;

  function automatic bit dep(input logic [4:0] a, input logic [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic int fsel(input logic [4:0] src);
    if (mem_reg_write && dep(mem_dst, src)) return 1;
    if (wb_reg_write && dep(wb_dst, src)) return 2;
    return 0;
  endfunction

  always @(negedge Clk) begin
    bit lu, fl, st;
    int e_pcw, e_ifw, e_iff, e_ixf, e_exf, e_fa, e_fb, e_ia, e_ib;
    if (!Reset) begin
      m_state = 0; m_stall = 0; m_flush = 0; m_stall3 = 0; m_flush3 = 0;
      e_pcw = 0; e_ifw = 0; e_iff = 1; e_ixf = 1; e_exf = 1;
      e_fa = 0; e_fb = 0; e_ia = 0; e_ib = 0;
      p_state = 0; p_stall = 0; p_flush = 0; p_stall3 = 0; p_flush3 = 0;
    end else begin
      lu = ex_mem_read && (dep(ex_dst, id_rs) || (id_uses_rt && dep(ex_dst, id_rt)));
      fl = mem_pc_src || ex_jr || id_jump;
      st = lu && !fl;
      e_pcw = st ? 0 : 1;
      e_ifw = st ? 0 : 1;
      e_iff = fl;
      e_ixf = mem_pc_src || ex_jr || st;
      e_exf = mem_pc_src;
      e_fa = fsel(ex_rs);
      e_fb = fsel(ex_rt);
      e_ia = wb_reg_write && dep(wb_dst, id_rs);
      e_ib = wb_reg_write && dep(wb_dst, id_rt);
      p_state  = fl ? 2 : (st ? 1 : 0);
      p_stall  = (st && m_stall < 65535) ? m_stall + 1 : m_stall;
      p_flush  = (fl && m_flush < 65535) ? m_flush + 1 : m_flush;
      p_stall3 = (st && m_stall3 < 7) ? m_stall3 + 1 : m_stall3;
      p_flush3 = (fl && m_flush3 < 7) ? m_flush3 + 1 : m_flush3;
    end
    chk("pc_write", pc_write, e_pcw);
    chk("ifid_write", ifid_write, e_ifw);
    chk("ifid_flush", ifid_flush, e_iff);
    chk("idex_flush", idex_flush, e_ixf);
    chk("exmem_flush", exmem_flush, e_exf);
    chk("fwd_a", fwd_a, e_fa);
    chk("fwd_b", fwd_b, e_fb);
    chk("fwd_id_a", fwd_id_a, e_ia);
    chk("fwd_id_b", fwd_id_b, e_ib);
    chk("hz_state", hz_state, m_state);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    chk("sat_stall_cnt", s_stall_cnt, m_stall3);
    chk("sat_flush_cnt", s_flush_cnt, m_flush3);
  end

  always @(posedge Clk) begin
    if (Reset) begin
      m_state = p_state; m_stall = p_stall; m_flush = p_flush;
      m_stall3 = p_stall3; m_flush3 = p_flush3;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_dst = 0; mem_dst = 0; wb_dst = 0;
    id_uses_rt = 0; ex_mem_read = 0; ex_jr = 0; mem_reg_write = 0;
    mem_pc_src = 0; wb_reg_write = 0; id_jump = 0;
  endtask

  initial begin
    // Reset values, forwarding forced off even with a live match
    clr();
    mem_reg_write = 1; mem_dst = 5; ex_rs = 5;
    #2;
    chk("rst_pc_write", pc_write, 0);
    chk("rst_ifid_write", ifid_write, 0);
    chk("rst_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_hz_state", hz_state, 0);
    tick(); tick();
    Reset = 1; clr();

    // Load-use stall
    ex_mem_read = 1; ex_dst = 2; id_rs = 2;
    #1;
    chk("lu_pc_write", pc_write, 0);
    chk("lu_ifid_write", ifid_write, 0);
    chk("lu_idex_flush", idex_flush, 1);
    tick();
    chk("lu_state", hz_state, 1);
    chk("lu_stall_cnt", stall_cnt, 1);
    ex_mem_read = 0;
    tick();
    chk("lu_back_run", hz_state, 0);

    // Forwarding priority
    clr();
    mem_reg_write = 1; mem_dst = 5; wb_reg_write = 1; wb_dst = 5; ex_rs = 5;
    #1 chk("fwd_mem", fwd_a, 1);
    mem_reg_write = 0;
    #1 chk("fwd_wb", fwd_a, 2);
    mem_reg_write = 1; mem_dst = 0; wb_dst = 0; ex_rs = 0;
    #1 chk("fwd_zero", fwd_a, 0);
    tick();

    // Branch flush with load-use
    clr();
    mem_pc_src = 1; ex_mem_read = 1; ex_dst = 3; id_rs = 3;
    #1;
    chk("br_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
    chk("br_pc_write", pc_write, 1);
    tick();
    chk("br_state", hz_state, 2);
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 1);

    clr(); ex_jr = 1;
    #1 chk("jr_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b110);
    tick();
    clr(); id_jump = 1; ex_mem_read = 1; ex_dst = 4; id_rs = 4;
    #1;
    chk("jmp_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b100);
    chk("jmp_pc_write", pc_write, 1);
    tick();
    chk("jmp_flush_cnt", flush_cnt, 3);
    chk("jmp_stall_cnt", stall_cnt, 1);

    // Saturation of the narrow counter: 9 stalls
    clr();
    for (int i = 0; i < 9; i++) begin
      ex_mem_read = 1; ex_dst = 1; id_rs = 1;
      tick();
      ex_mem_read = 0;
      tick();
    end
    chk("sat_hold", s_stall_cnt, 7);
    chk("wide_stall_cnt", stall_cnt, 10);

    // Asynchronous reset mid-stall
    ex_mem_read = 1; ex_dst = 6; id_rs = 6;
    tick();
    chk("pre_rst_state", hz_state, 1);
    ex_mem_read = 0;
    #2 Reset = 0;
    #1;
    chk("arst_state", hz_state, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_flush_cnt", flush_cnt, 0);
    chk("arst_pc_write", pc_write, 0);
    tick();
    Reset = 1;
    ex_mem_read = 1; ex_dst = 6; id_rs = 6;
    #1 chk("post_rst_pc_write", pc_write, 0);
    tick();
    chk("post_rst_state", hz_state, 1);
    chk("post_rst_stall_cnt", stall_cnt, 1);
    ex_mem_read = 0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      ex_dst = 5'($urandom_range(0, 3));
      mem_dst = 5'($urandom_range(0, 3));
      wb_dst = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_mem_read = (m_state == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_reg_write = 1'($urandom_range(0, 1));
      mem_pc_src = ($urandom_range(0, 9) == 0);
      ex_jr = ($urandom_range(0, 9) == 0);
      id_jump = ($urandom_range(0, 9) == 0);
      Reset = ($urandom_range(0, 199) != 0);
      tick();
    end
    Reset = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
